// File: rtl/instruction_encoder.sv
// instruction_encoder
// Host-side transmitter. It turns host commands (NOP, SPK, RUN, CLR) into fixed-width
// instruction words for network_source. It buffers commands and splits long runs into
// legal RUN_WIDTH-sized chunks.
//
// Word format: instr[INSTR_WIDTH-1 -: 2] = opcode (0 NOP, 1 SPK, 2 RUN, 3 CLR).
//   SPK: {idx, val} in the low IDX_WIDTH+VAL_WIDTH bits, with val in the LSBs.
//   RUN: chunk count in the low RUN_WIDTH bits.
//   NOP/CLR: payload is zero.
//
// Configuration macro INSTR_ENC_FIFO_EN:
//   defined   -> FIFO_DEPTH-entry command FIFO feeds a one-entry holding register.
//                Latency is 2 and the design sustains one word per cycle across commands.
//   undefined -> only the holding register is present. It is refilled in the cycle
//                after it is popped, and latency is 1.
//
// Ports:
//   clk, arst                 clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_op/idx/val/len        command fields
//   instr_valid/instr_ready   instruction handshake towards the processor
//   instr                     registered instruction word
//   busy                      any command buffered, split in progress or word pending
module instruction_encoder #(
  parameter int INSTR_WIDTH = 32,
  parameter int RUN_WIDTH   = 8,
  parameter int IDX_WIDTH   = 8,
  parameter int VAL_WIDTH   = 8,
  parameter int LEN_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [IDX_WIDTH-1:0]   cmd_idx,
  input  logic [VAL_WIDTH-1:0]   cmd_val,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   busy
);

  localparam int CMD_W = 2 + IDX_WIDTH + VAL_WIDTH + LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAXR = LEN_WIDTH'((64'd1 << RUN_WIDTH) - 64'd1);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_SPK = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   rem;
  logic [CMD_W-1:0]       cmd_in;
  logic [CMD_W-1:0]       hold_q;
  logic [CMD_W-1:0]       hold_din;
  logic                   hold_valid;
  logic                   hold_load;
  logic                   hold_pop;
  logic                   out_free;
  logic                   fifo_busy;
  logic [1:0]             hold_op;
  logic [IDX_WIDTH-1:0]   hold_idx;
  logic [VAL_WIDTH-1:0]   hold_val;
  logic [LEN_WIDTH-1:0]   hold_len;

  function automatic logic [INSTR_WIDTH-1:0] run_word(input logic [RUN_WIDTH-1:0] count);
    logic [INSTR_WIDTH-1:0] w;
    w = '0;
    w[INSTR_WIDTH-1 -: 2] = OP_RUN;
    w[RUN_WIDTH-1:0] = count;
    return w;
  endfunction

  // Encodes NOP, SPK and CLR. The payload is filled only for SPK.
  function automatic logic [INSTR_WIDTH-1:0] plain_word(input logic [1:0] op,
                                                        input logic [IDX_WIDTH-1:0] idx,
                                                        input logic [VAL_WIDTH-1:0] val);
    logic [INSTR_WIDTH-1:0] w;
    w = '0;
    w[INSTR_WIDTH-1 -: 2] = op;
    if (op == OP_SPK) begin
      w[IDX_WIDTH+VAL_WIDTH-1:0] = {idx, val};
    end
    return w;
  endfunction

  assign cmd_in = {cmd_op, cmd_idx, cmd_val, cmd_len};
  assign {hold_op, hold_idx, hold_val, hold_len} = hold_q;

  // The output register can accept a new word when it is empty or is being taken this cycle.
  assign out_free = !instr_valid || instr_ready;
  // The holding register is consumed only by IDLE. SPLIT never pops a command.
  assign hold_pop = (state == ST_IDLE) && hold_valid && out_free;

`ifdef INSTR_ENC_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready  = !fifo_full && !arst;
  assign fifo_push  = cmd_valid && cmd_ready;
  // The holding register refills in the same cycle it is popped, which keeps back-to-back
  // commands at one word per cycle.
  assign fifo_pop   = !fifo_empty && (!hold_valid || hold_pop);
  assign hold_load  = fifo_pop;
  assign hold_din   = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign fifo_busy  = !fifo_empty;

  // FIFO pointer update. A reset empties the queue.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage. It needs no reset because the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= cmd_in;
  end
`else
  // The holding register accepts only when it is empty, so a pop and a refill never
  // happen in the same cycle.
  assign cmd_ready = !hold_valid && !arst;
  assign hold_load = cmd_valid && cmd_ready;
  assign hold_din  = cmd_in;
  assign fifo_busy = 1'b0;
`endif

  // Holding register: keeps the next whole command that the FSM will decode.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hold_valid <= 1'b0;
      hold_q     <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_q     <= hold_din;
    end else if (hold_pop) begin
      hold_valid <= 1'b0;
    end
  end

  // Encoder FSM and output register. IDLE decodes one command per free output slot.
  // SPLIT emits MAXR chunks until the remainder fits in one word. Nothing changes
  // while the consumer stalls a valid word.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= ST_IDLE;
      rem         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (out_free) begin
            if (hold_valid) begin
              if (hold_op == OP_RUN) begin
                if (hold_len == '0) begin
                  instr_valid <= 1'b0;
                end else if (hold_len <= MAXR) begin
                  instr       <= run_word(RUN_WIDTH'(hold_len));
                  instr_valid <= 1'b1;
                end else begin
                  instr       <= run_word(RUN_WIDTH'(MAXR));
                  instr_valid <= 1'b1;
                  rem         <= hold_len - MAXR;
                  state       <= ST_SPLIT;
                end
              end else begin
                instr       <= plain_word(hold_op, hold_idx, hold_val);
                instr_valid <= 1'b1;
              end
            end else begin
              instr_valid <= 1'b0;
            end
          end
        end
        ST_SPLIT: begin
          if (out_free) begin
            instr_valid <= 1'b1;
            if (rem > MAXR) begin
              instr <= run_word(RUN_WIDTH'(MAXR));
              rem   <= rem - MAXR;
            end else begin
              instr <= run_word(RUN_WIDTH'(rem));
              rem   <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = fifo_busy || hold_valid || (state != ST_IDLE) || instr_valid;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Host-side transmitter that turns high-level commands (apply spike, run N cycles, clear, no-op) into the fixed-width instruction words consumed by `network_source`. It sits between the host command path (UART/DMA front end) and the processor's `instr` input. It buffers commands and splits long runs into legal `RUN_WIDTH`-sized chunks. Its valid/ready output feeds the processor's instruction handshake directly.

## Interface
- `INSTR_WIDTH`, 32: output instruction width; must be ≥ 2 + max(`IDX_WIDTH`+`VAL_WIDTH`, `RUN_WIDTH`).
- `RUN_WIDTH`, 8: width of the RUN count field; max chunk `MAXR` = 2^`RUN_WIDTH` − 1.
- `IDX_WIDTH`, 8: input-neuron index width.
- `VAL_WIDTH`, 8: spike charge width, two's complement.
- `LEN_WIDTH`, 32: host run-length width.
- `FIFO_DEPTH`, 4: command FIFO entries, power of two ≥ 2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at an edge.
- `cmd_op` in 2: 0 NOP, 1 SPK, 2 RUN, 3 CLR.
- `cmd_idx` in `IDX_WIDTH`: SPK index.
- `cmd_val` in `VAL_WIDTH`: SPK charge.
- `cmd_len` in `LEN_WIDTH`: RUN length in cycles.
- `instr_valid` out 1: `instr` holds a word.
- `instr_ready` in 1: consumer takes word when `instr_valid && instr_ready` at an edge.
- `instr` out `INSTR_WIDTH`: encoded instruction.
- `busy` out 1: FIFO non-empty, FSM not IDLE, or `instr_valid` high.

## Operation
- Word format: `instr[INSTR_WIDTH-1 -: 2]` = opcode, same code as `cmd_op`. All unused bits are 0.
  - SPK: `{idx, val}` in the low `IDX_WIDTH+VAL_WIDTH` bits, `val` in the LSBs.
  - RUN: chunk count in the low `RUN_WIDTH` bits.
  - NOP and CLR: payload zero.
- Command FIFO: `cmd_ready` = !full && !`arst`. Commands are stored whole, in order.
- FSM states:
  - IDLE: when the FIFO is non-empty and the output register is free (!`instr_valid` || `instr_ready`), pop one command.
    - NOP, SPK, CLR: load the word and stay in IDLE.
    - RUN with `cmd_len` = 0: drop it, emit nothing, stay in IDLE.
    - RUN with `cmd_len` ≤ `MAXR`: emit a single RUN word and stay in IDLE.
    - RUN with `cmd_len` > `MAXR`: emit RUN `MAXR`, load `rem` = `cmd_len` − `MAXR`, go to SPLIT.
  - SPLIT: when the output register is free, emit RUN min(`rem`, `MAXR`) and subtract that amount from `rem`. Return to IDLE when `rem` reaches 0. No FIFO pops happen in SPLIT.
- `rem` is `LEN_WIDTH` bits and never underflows.
- Total emitted RUN count equals `cmd_len` exactly. Chunks are `MAXR`,…,`MAXR`, remainder, where the remainder is in 1..`MAXR`.
- Output register: `instr` and `instr_valid` are registered. While `instr_valid && !instr_ready`, `instr` is held stable. It loads a new word, or clears `instr_valid`, only when free.
- Simultaneous push and pop on a full FIFO: the push is refused (`cmd_ready` = 0 while full).

## Timing
- Reset values: `instr_valid` = 0, `instr` = 0, `busy` = 0, `cmd_ready` = 0 while `arst` is high and 1 after release. The FIFO is emptied, the FSM is in IDLE, `rem` = 0.
- Reset mid-SPLIT abandons the remaining chunks. No partial word is emitted after release.
- Latency: a command accepted at edge N gives its first word valid after edge N+2, with FIFO empty and consumer ready.
- Throughput: one word per cycle while `instr_ready` is held at 1, including across command boundaries and SPLIT chunks.
- Backpressure: `instr_ready` low stalls the FSM with no loss and no duplication.

## Configuration
- `INSTR_ENC_FIFO_EN` defined: FIFO of `FIFO_DEPTH` entries as above, latency 2.
- `INSTR_ENC_FIFO_EN` undefined: a single command holding register replaces the FIFO.
  - `cmd_ready` = register empty && !`arst`.
  - The register is refilled in the cycle after its pop.
  - Latency 1: first word valid after edge N+1.
  - `FIFO_DEPTH` is ignored. The word format is identical.

## Test plan
- `RUN_WIDTH`=4, RUN `cmd_len`=40, `instr_ready`=1 → RUN 15, RUN 15, RUN 10 on consecutive cycles, then `busy`=0.
- SPK idx 3, val −2 (8/8) → opcode 1, low 16 bits 0x03FE. RUN `cmd_len`=0 → no word, next command emitted directly.
- `instr_ready`=0 for 5 cycles after the first word → `instr` stable. All 4 queued commands (FIFO_DEPTH=4) emerge in order. `cmd_ready`=0 while full.
- Commands CLR, NOP, RUN 1 back-to-back → opcodes 3, 0, 2(count 1) on three consecutive cycles.
- `arst` pulsed during the SPLIT of RUN 40 → `instr_valid`=0, `busy`=0 immediately. After release, a new RUN 5 yields exactly one RUN 5.
- Random `cmd_valid` and `instr_ready` over 10k commands → scoreboard: word sequence matches the reference encoding, RUN sums match, no drops or duplicates.
